hazard_ctrl_unit: RTL

Parametrised hazard controller for the pipelined RISC-V core, combining operand forwarding, load-use interlock and a register scoreboard for long-latency (MUL/DIV) results. It sits beside the ID/EX boundary. It drives per-operand forwarding selects into the EX operand muxes, and stall/bubble controls into the IF/ID and ID/EX pipeline registers. Unlike the fixed two-operand, two-stage forwarder, stage count and operand count are parameters, and it holds state: the scoreboard and stall statistics.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_scoreboard.sv | 53 +++++
 rtl/hazard_ctrl_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared constants, select mapping and hazard-cause encoding
//                for the pipeline hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Forwarding select value meaning "take the operand from the register file"
    localparam int unsigned FWD_SEL_RF = 0;

    // Debug classification of the dominant hazard in the current cycle
    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_SB_RAW   = 2'd2,
        HZ_SB_WAW   = 2'd3
    } hz_cause_e;

    // Forwarding stage k is selected by value k+1; 0 is reserved for the RF
    function automatic int unsigned stage_to_sel(input int unsigned stage);
        return stage + 1;
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Pending-write bit per architectural register for results
//                still in flight in the long-latency unit. A set and a clear
//                of the same register in one cycle resolve to set, since the
//                set represents a newer outstanding issue. x0 never pends.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_AW-1:0]     set_addr,
    input  logic                  clr_en,
    input  logic [REG_AW-1:0]     clr_addr,
    output logic [2**REG_AW-1:0]  pending
);

    localparam int NREG = 2**REG_AW;

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_next;

    // Next pending vector: clear first, then set, so set dominates
    always_comb begin
        w_next = r_pending;
        if (clr_en) begin
            w_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            w_next[set_addr] = 1'b1;
        end
        w_next[0] = 1'b0;
    end

    // Pending register with synchronous reset dropping all entries
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_next;
        end
    end

    assign pending = r_pending;

endmodule : hazard_scoreboard
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_unit
//  Description : Operand forwarding selects, load-use interlock and long-
//                latency scoreboard interlock for the EX/ID pipeline
//                boundary, with saturating stall statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = $clog2(NUM_FWD + 1),
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]          id_rs_used,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_is_long,
    input  logic                        id_flush,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic                        ex_mem_read,
    input  logic [NUM_FWD*REG_AW-1:0]   fwd_rd,
    input  logic [NUM_FWD-1:0]          fwd_we,
    input  logic                        long_done,
    input  logic [REG_AW-1:0]           long_done_rd,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        stall_id,
    output logic                        bubble_ex,
    output logic [2**REG_AW-1:0]        sb_pending,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            lu_stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    hz_cause_e         w_hz_cause;
    logic              w_stall;
    logic              w_sb_set;
    logic              w_sb_clr;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_lu_stall_cnt;

    // Per-operand forwarding priority encoder
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd_op
        logic [REG_AW-1:0] w_src;
        logic [SEL_W-1:0]  w_sel;

        assign w_src = ex_rs[gi*REG_AW +: REG_AW];

        // Scan oldest to youngest so the youngest matching producer wins
        always_comb begin
            w_sel = SEL_W'(FWD_SEL_RF);
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_we[k] && (fwd_rd[k*REG_AW +: REG_AW] != '0) &&
                    (fwd_rd[k*REG_AW +: REG_AW] == w_src)) begin
                    w_sel = SEL_W'(stage_to_sel(k));
                end
            end
            if (rst) begin
                w_sel = SEL_W'(FWD_SEL_RF);
            end
        end

        assign fwd_sel[gi*SEL_W +: SEL_W] = w_sel;
    end

    // Hazard classification; load-use ranks first so the counter sees it
    always_comb begin
        logic w_lu;
        logic w_raw;
        logic w_waw;
        w_lu  = 1'b0;
        w_raw = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && ex_mem_read && (ex_rd != '0) &&
                (id_rs[i*REG_AW +: REG_AW] == ex_rd)) begin
                w_lu = 1'b1;
            end
            if (id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] != '0) &&
                sb_pending[id_rs[i*REG_AW +: REG_AW]]) begin
                w_raw = 1'b1;
            end
        end
        w_waw = id_is_long && (id_rd != '0) && sb_pending[id_rd];

        if (w_lu) begin
            w_hz_cause = HZ_LOAD_USE;
        end else if (w_raw) begin
            w_hz_cause = HZ_SB_RAW;
        end else if (w_waw) begin
            w_hz_cause = HZ_SB_WAW;
        end else begin
            w_hz_cause = HZ_NONE;
        end
    end

    assign w_stall   = (w_hz_cause != HZ_NONE) && !id_flush && !rst;
    assign stall_id  = w_stall;
    assign bubble_ex = w_stall;

    // A long op only becomes outstanding once it actually leaves ID
    assign w_sb_set = id_is_long && !w_stall && !id_flush && (id_rd != '0);
    assign w_sb_clr = long_done && (long_done_rd != '0);

    hazard_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (w_sb_set),
        .set_addr (id_rd),
        .clr_en   (w_sb_clr),
        .clr_addr (long_done_rd),
        .pending  (sb_pending)
    );

    // Saturating stall statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt    <= '0;
            r_lu_stall_cnt <= '0;
        end else if (w_stall) begin
            if (r_stall_cnt != c_cnt_max) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if ((w_hz_cause == HZ_LOAD_USE) && (r_lu_stall_cnt != c_cnt_max)) begin
                r_lu_stall_cnt <= r_lu_stall_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign lu_stall_cnt = r_lu_stall_cnt;

endmodule : hazard_ctrl_unit
`default_nettype wire
